// File: rtl/pwm_switch_bank.sv
// Multi-channel PWM bank: programmable prescaler, shared period counter, double-buffered duties.
// Optional PWM_CENTER_ALIGN_EN switches the counter to up/down (center-aligned) mode.
module pwm_switch_bank #(
    parameter int CH  = 4,
    parameter int CHW = 2,
    parameter int CW  = 8,
    parameter int PW  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [PW-1:0]  presc_max,
    input  logic [CW-1:0]  period_max,
    input  logic           wr_valid,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_duty,
    output logic           wr_ready,
    output logic           tick,
    output logic           period_start,
    output logic [CW-1:0]  cnt,
    output logic [CH-1:0]  pwm_out
);

    logic [PW-1:0] presc;
    logic [CW-1:0] shadow [CH];
    logic [CW-1:0] active [CH];
    logic [CH-1:0] pending;
    logic          ch_in_range;
    logic          ch_pending;
    logic          wr_fire;

    // Channel selects beyond CH are never ready, so their writes are dropped
    always_comb begin
        ch_in_range = 32'(wr_ch) < CH;
        ch_pending  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (32'(wr_ch) == i) begin
                ch_pending = pending[i];
            end
        end
        wr_ready = reset & ch_in_range & ~ch_pending;
        wr_fire  = wr_valid & wr_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (presc >= presc_max) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down;

    // Up 0..period_max, then down; the period restarts when the down-count reaches 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            if (tick) begin
                if (!dir_down) begin
                    if (cnt >= period_max) begin
                        if (cnt == '0) begin
                            period_start <= 1'b1;
                        end else begin
                            cnt      <= cnt - 1'b1;
                            dir_down <= 1'b1;
                            if (cnt == CW'(1)) begin
                                period_start <= 1'b1;
                                dir_down     <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (cnt <= CW'(1)) begin
                    cnt          <= '0;
                    dir_down     <= 1'b0;
                    period_start <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
`else
    // The >= compare lets a lowered period_max take effect on the next tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= 1'b0;
            if (tick) begin
                if (cnt >= period_max) begin
                    cnt          <= '0;
                    period_start <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
`endif

    // A write landing with period_start sets pending only after this load has sampled it
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= cnt < active[i];
                if (period_start && pending[i]) begin
                    active[i]  <= shadow[i];
                    pending[i] <= 1'b0;
                end
                if (wr_fire && 32'(wr_ch) == i) begin
                    shadow[i]  <= wr_duty;
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_switch_bank.sv
// Randomized and directed bench for pwm_switch_bank against a behavioural reference model.
module tb_pwm_switch_bank;

    localparam int CH  = 4;
    localparam int CHW = 3;
    localparam int CW  = 8;
    localparam int PW  = 5;

    logic           clk;
    logic           reset;
    logic           en;
    logic [PW-1:0]  presc_max;
    logic [CW-1:0]  period_max;
    logic           wr_valid;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_duty;
    logic           wr_ready;
    logic           tick;
    logic           period_start;
    logic [CW-1:0]  cnt;
    logic [CH-1:0]  pwm_out;

    pwm_switch_bank #(.CH(CH), .CHW(CHW), .CW(CW), .PW(PW)) dut (
        .clk(clk), .reset(reset), .en(en), .presc_max(presc_max),
        .period_max(period_max), .wr_valid(wr_valid), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .wr_ready(wr_ready), .tick(tick),
        .period_start(period_start), .cnt(cnt), .pwm_out(pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_passed = 0;

    // Reference state: prescaler phase, period position, per-channel duty buffers
    int m_p, m_tick, m_cnt, m_ps;
    int m_shadow [CH];
    int m_active [CH];
    int m_pend [CH];
    int m_pwm [CH];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int model_ready();
        if (!reset) return 0;
        if (int'(wr_ch) >= CH) return 0;
        return (m_pend[int'(wr_ch)] == 0) ? 1 : 0;
    endfunction

    function automatic logic [CH-1:0] model_pwm();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (m_pwm[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        m_p = 0; m_tick = 0; m_cnt = 0; m_ps = 0;
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0; m_active[i] = 0; m_pend[i] = 0; m_pwm[i] = 0;
        end
    endtask

    task automatic model_clock(input int fire);
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < CH; i++) m_pwm[i] = (m_cnt < m_active[i]) ? 1 : 0;
        for (int i = 0; i < CH; i++) begin
            if (m_ps != 0 && m_pend[i] != 0) begin
                m_active[i] = m_shadow[i];
                m_pend[i] = 0;
            end
        end
        if (fire != 0) begin
            m_shadow[int'(wr_ch)] = int'(wr_duty);
            m_pend[int'(wr_ch)] = 1;
        end
        m_ps = 0;
        if (m_tick != 0) begin
            if (m_cnt >= int'(period_max)) begin
                m_cnt = 0;
                m_ps = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (en) begin
            if (m_p >= int'(presc_max)) begin
                m_p = 0; m_tick = 1;
            end else begin
                m_p = m_p + 1; m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endtask

    // Check the combinational ready, clock once, then check all registered outputs
    task automatic applyStimulus(input int cycles);
        int fire;
        for (int c = 0; c < cycles; c++) begin
            #1;
            checkOutput("wr_ready", 32'(wr_ready), 32'(model_ready()));
            fire = (wr_valid && model_ready() != 0) ? 1 : 0;
            @(posedge clk);
            model_clock(fire);
            #1;
            checkOutput("tick", 32'(tick), 32'(m_tick));
            checkOutput("period_start", 32'(period_start), 32'(m_ps));
            checkOutput("cnt", 32'(cnt), 32'(m_cnt));
            checkOutput("pwm_out", 32'(pwm_out), 32'(model_pwm()));
        end
    endtask

    task automatic write_once(input int ch, input int duty);
        wr_valid = 1'b1; wr_ch = CHW'(ch); wr_duty = CW'(duty);
        applyStimulus(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        reset = 1'b0; en = 1'b1; presc_max = 5'd4; period_max = 8'd9;
        wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;
        applyStimulus(3);
        checkOutput("reset_pwm", 32'(pwm_out), 32'd0);
        checkOutput("reset_ready", 32'(wr_ready), 32'd0);

        reset = 1'b1;
        applyStimulus(4);
        checkOutput("no_tick_before_5th", 32'(tick), 32'd0);
        applyStimulus(1);
        checkOutput("first_tick_5th", 32'(tick), 32'd1);
        applyStimulus(10);

        presc_max = 5'd0;
        write_once(0, 3);
        write_once(1, 10);
        applyStimulus(30);
        checkOutput("ch1_const_high", 32'(pwm_out[1]), 32'd1);

        write_once(2, 5);
        applyStimulus(14);
        write_once(2, 7);
        wr_valid = 1'b1; wr_ch = 3'd2; wr_duty = 8'd7;
        applyStimulus(12);
        wr_valid = 1'b0;
        applyStimulus(12);

        en = 1'b0;
        applyStimulus(2);
        write_once(3, 4);
        applyStimulus(3);
        checkOutput("freeze_tick", 32'(tick), 32'd0);
        en = 1'b1;
        applyStimulus(5);

        guard = 0;
        while (m_cnt != 8 && guard < 40) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("reach_cnt8", 32'(m_cnt == 8), 32'd1);
        period_max = 8'd3;
        applyStimulus(3);
        wr_valid = 1'b1; wr_ch = 3'd5; wr_duty = 8'd2;
        applyStimulus(2);
        checkOutput("range_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;

        for (int r = 0; r < 400; r++) begin
            reset = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) presc_max = PW'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) period_max = CW'($urandom_range(0, 12));
            wr_valid = ($urandom_range(0, 9) < 3);
            wr_ch = CHW'($urandom_range(0, 5));
            wr_duty = CW'($urandom_range(0, 14));
            applyStimulus(1);
        end

        reset = 1'b1; en = 1'b1; wr_valid = 1'b0;
        applyStimulus(2);
        guard = 0;
        while ((m_pend[0] != 0 || m_pend[3] != 0) && guard < 100) begin
            applyStimulus(1);
            guard++;
        end
        write_once(0, 6);
        write_once(3, 2);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("midreset_cnt", 32'(cnt), 32'd0);
        checkOutput("midreset_pwm", 32'(pwm_out), 32'd0);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("midreset_ready0", 32'(wr_ready), 32'(wr_ch < 3'd4));
        applyStimulus(20);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
